multi_cycle_adder: RTL



---
 rtl/multi_cycle_adder_if.sv | 24 ++
 rtl/multi_cycle_adder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/multi_cycle_adder_if.sv
// rtl/multi_cycle_adder_if.sv - request/result bundle for multi_cycle_adder
// ovf is present only when ADDER_OVERFLOW_EN is defined.
interface multi_cycle_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_OVERFLOW_EN
  logic             ovf;

  modport master (output start, a, b, cin, sub, input ready, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output ready, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, sub, input ready, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output ready, done, sum, cout);
`endif
endinterface

// File: rtl/multi_cycle_adder.sv
// rtl/multi_cycle_adder.sv - WIDTH-bit add/sub computed DIGIT bits per clock
// Optional signed overflow output enabled by ADDER_OVERFLOW_EN.
module multi_cycle_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  multi_cycle_adder_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("multi_cycle_adder: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef ADDER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] acc_next;

  // Low slice of each operand plus ripple carry; the result enters the working sum from the top.
  assign slice    = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
  assign acc_next = (acc_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_next;
        carry_d = slice[DIGIT];
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = acc_next;
          cout_d  = slice[DIGIT];
`ifdef ADDER_OVERFLOW_EN
          // Carry into the MSB is recovered from the MSB operand bits and sum bit.
          ovf_d   = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ slice[DIGIT-1] ^ slice[DIGIT];
`endif
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
`ifdef ADDER_OVERFLOW_EN
  assign bus.ovf   = ovf_q;
`endif
endmodule
